ex_mac_seq: RTL and testbench

Sequencer for the shared 4x4 multiply-add datapath (S = A*B + C, 8-bit). It accepts a job of N operand pairs and feeds them one at a time to the datapath, feeding the previous S back in as C, then returns the 8-bit dot-product result with a one-cycle done pulse. Operand pairs arrive over a valid/ready stream; the datapath itself is outside this block and is reached through the mac_* ports.

---
 rtl/ex_mac_seq.sv | 118 +++++++++++
 tb/tb_ex_mac_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mac_seq.sv
// Sequencer for the shared 4x4 multiply-add datapath: streams N operand pairs through
// S = A*B + C, feeding S back as C, and reports the final accumulator with a done pulse.
module ex_mac_seq #(
  parameter int unsigned LAT = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [3:0] len,
  input  logic [7:0] init,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] mac_a,
  output logic [3:0] mac_b,
  output logic [7:0] mac_c,
  input  logic [7:0] mac_s,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [3:0]  rem_q, rem_d;
  logic [1:0]  wait_q, wait_d;
  logic [3:0]  mac_a_q, mac_a_d;
  logic [3:0]  mac_b_q, mac_b_d;
  logic [7:0]  result_q, result_d;
  logic        wait_last;

  // The datapath output is valid after LAT cycles; sample it on the (LAT+1)-th WAIT edge.
  assign wait_last = (wait_q == 2'(LAT));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    wait_d   = wait_q;
    mac_a_d  = mac_a_q;
    mac_b_d  = mac_b_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = init;
          rem_d = len;
          if (len == 4'd0) begin
            state_d  = StDone;
            result_d = init;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (in_valid) begin
          mac_a_d = in_a;
          mac_b_d = in_b;
          wait_d  = 2'd0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_last) begin
          acc_d = mac_s;
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d  = StDone;
            result_d = mac_s;
          end else begin
            state_d = StFetch;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      acc_q    <= 8'd0;
      rem_q    <= 4'd0;
      wait_q   <= 2'd0;
      mac_a_q  <= 4'd0;
      mac_b_q  <= 4'd0;
      result_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      wait_q   <= wait_d;
      mac_a_q  <= mac_a_d;
      mac_b_q  <= mac_b_d;
      result_q <= result_d;
    end
  end

  assign in_ready = (state_q == StFetch);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign mac_c    = acc_q;
  assign result   = result_q;

endmodule

// File: tb/tb_ex_mac_seq.sv
// Directed bench for ex_mac_seq: one instance with LAT=1, one with LAT=2, each wired to a
// behavioural multiply-add datapath of matching latency.
module tb_ex_mac_seq;

  logic       clk = 1'b0;
  logic       clear;
  logic       start1, start2;
  logic [3:0] len;
  logic [7:0] init;
  logic       in_valid;
  logic [3:0] in_a, in_b;

  logic       in_ready1, busy1, done1;
  logic [3:0] mac_a1, mac_b1;
  logic [7:0] mac_c1, mac_s1, result1;
  logic       in_ready2, busy2, done2;
  logic [3:0] mac_a2, mac_b2;
  logic [7:0] mac_c2, mac_s2, result2;

  logic [7:0] s1_q, s2a_q, s2b_q;

  always #5 clk = ~clk;

  ex_mac_seq #(.LAT(1)) u_dut1 (
    .clk(clk), .clear(clear), .start(start1), .len(len), .init(init),
    .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a1), .mac_b(mac_b1), .mac_c(mac_c1), .mac_s(mac_s1),
    .busy(busy1), .done(done1), .result(result1)
  );

  ex_mac_seq #(.LAT(2)) u_dut2 (
    .clk(clk), .clear(clear), .start(start2), .len(len), .init(init),
    .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a2), .mac_b(mac_b2), .mac_c(mac_c2), .mac_s(mac_s2),
    .busy(busy2), .done(done2), .result(result2)
  );

  // Datapath models: S = A*B + C mod 256, delayed by LAT clock edges
  always @(posedge clk) begin
    s1_q  <= {4'b0, mac_a1} * {4'b0, mac_b1} + mac_c1;
    s2a_q <= {4'b0, mac_a2} * {4'b0, mac_b2} + mac_c2;
    s2b_q <= s2a_q;
  end
  assign mac_s1 = s1_q;
  assign mac_s2 = s2b_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  logic [3:0] pa[16];
  logic [3:0] pb[16];
  int         done_edge, hs, dones, rdy_seen;
  logic [7:0] res, mac_c_wait;
  bit         stall_bad;

  // Drives one job into the selected instance with in_valid high except for stall_cyc
  // FETCH cycles before pair stall_idx; done_edge counts edges after the start edge.
  task automatic run_job(input int sel, input logic [7:0] ini, input int n,
                         input int stall_idx, input int stall_cyc, input int restart_e);
    int   idx;
    int   stall_left;
    logic hs_now;
    bit   got_wait;
    idx = 0; stall_left = stall_cyc; done_edge = -1; hs = 0; dones = 0; rdy_seen = 0;
    stall_bad = 0; got_wait = 0; res = 8'd0; mac_c_wait = 8'd0;
    @(posedge clk); #1;
    init = ini; len = 4'(n);
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    in_a = pa[0]; in_b = pb[0];
    in_valid = (n > 0) && !(stall_idx == 0 && stall_left > 0);
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    for (int e = 0; e < 80; e++) begin
      logic       rdy, bsy, dn;
      logic [7:0] r, mc;
      logic [3:0] ma, mb;
      rdy = (sel == 1) ? in_ready1 : in_ready2;
      bsy = (sel == 1) ? busy1     : busy2;
      dn  = (sel == 1) ? done1     : done2;
      r   = (sel == 1) ? result1   : result2;
      mc  = (sel == 1) ? mac_c1    : mac_c2;
      ma  = (sel == 1) ? mac_a1    : mac_a2;
      mb  = (sel == 1) ? mac_b1    : mac_b2;
      if (dn) begin
        dones++;
        if (done_edge < 0) begin
          done_edge = e;
          res = r;
        end
      end
      if (done_edge >= 0 && e >= done_edge + 3) break;
      if (rdy) rdy_seen++;
      if (bsy && !rdy && !dn && !got_wait) begin
        mac_c_wait = mc;
        got_wait = 1;
      end
      hs_now = in_valid & rdy;
      if (rdy && !in_valid && stall_left > 0) begin
        stall_left--;
        if (idx > 0 && (ma != pa[idx-1] || mb != pb[idx-1])) stall_bad = 1;
      end
      start1 = 1'b0; start2 = 1'b0;
      if (e == restart_e) begin
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
      end
      @(posedge clk); #1;
      if (hs_now) begin
        idx++;
        hs++;
      end
      if (idx < n) begin
        in_a = pa[idx]; in_b = pb[idx];
      end
      in_valid = (idx < n) && !(idx == stall_idx && stall_left > 0);
    end
    start1 = 1'b0; start2 = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    clear = 1'b0; start1 = 1'b0; start2 = 1'b0; len = 4'd0; init = 8'd0;
    in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
    #1;
    check_eq("reset_dut1", {5'd0, in_ready1, busy1, done1, mac_a1, mac_b1, mac_c1, result1}, 0);
    check_eq("reset_dut2", {5'd0, in_ready2, busy2, done2, mac_a2, mac_b2, mac_c2, result2}, 0);
    repeat (2) @(negedge clk);
    clear = 1'b1;

    // LAT=1 three-pair job: 1 + 3 + 12 + 27 = 43
    pa[0] = 4'd3; pb[0] = 4'd1; pa[1] = 4'd6; pb[1] = 4'd2; pa[2] = 4'd9; pb[2] = 4'd3;
    run_job(1, 8'd1, 3, -1, 0, -1);
    check_eq("dot3_result", res, 43);
    check_eq("dot3_done_edge", done_edge, 9);
    check_eq("dot3_handshakes", hs, 3);
    check_eq("dot3_done_pulses", dones, 1);
    check_eq("dot3_result_held", result1, 43);

    // Wrap: 250 + 225 = 475 mod 256 = 219
    pa[0] = 4'd15; pb[0] = 4'd15;
    run_job(1, 8'd250, 1, -1, 0, -1);
    check_eq("wrap_result", res, 219);
    check_eq("wrap_mac_c_wait", mac_c_wait, 250);
    check_eq("wrap_done_edge", done_edge, 3);

    // Empty job
    run_job(1, 8'h5A, 0, -1, 0, -1);
    check_eq("len0_result", res, 8'h5A);
    check_eq("len0_done_edge", done_edge, 0);
    check_eq("len0_in_ready", rdy_seen, 0);
    check_eq("len0_done_pulses", dones, 1);

    // LAT=2: 16 + 6 = 22, baseline then with a 3-cycle stall before the second pair
    pa[0] = 4'd4; pb[0] = 4'd4; pa[1] = 4'd2; pb[1] = 4'd3;
    run_job(2, 8'd0, 2, -1, 0, -1);
    check_eq("bp_base_result", res, 22);
    check_eq("bp_base_done_edge", done_edge, 8);
    run_job(2, 8'd0, 2, 1, 3, -1);
    check_eq("bp_stall_result", res, 22);
    check_eq("bp_stall_done_edge", done_edge, 11);
    check_eq("bp_stall_handshakes", hs, 2);
    check_eq("bp_stall_mac_stable", stall_bad, 0);

    // Start pulsed mid-job must be ignored: 7 + 1 + 1 = 9
    pa[0] = 4'd1; pb[0] = 4'd1; pa[1] = 4'd1; pb[1] = 4'd1;
    run_job(1, 8'd7, 2, -1, 0, 2);
    check_eq("restart_result", res, 9);
    check_eq("restart_done_pulses", dones, 1);
    check_eq("restart_done_edge", done_edge, 6);

    // Asynchronous clear during the second pair's WAIT
    @(posedge clk); #1;
    init = 8'd0; len = 4'd2; in_a = 4'd1; in_b = 4'd1; in_valid = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_pre_wait", {busy1, in_ready1}, 2'b10);
    #2 clear = 1'b0;
    #1;
    check_eq("abort_outputs", {5'd0, in_ready1, busy1, done1, mac_a1, mac_b1, mac_c1, result1}, 0);
    in_valid = 1'b0;
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done1) dones++;
    end
    check_eq("abort_no_done", dones, 0);
    @(negedge clk);
    clear = 1'b1;

    // 3 + 2*2 = 7
    pa[0] = 4'd2; pb[0] = 4'd2;
    run_job(1, 8'd3, 1, -1, 0, -1);
    check_eq("post_reset_result", res, 7);
    check_eq("post_reset_done_edge", done_edge, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
